elevator_scheduler: RTL and testbench
=====================================

Name: elevator_scheduler

Overview:
Controller for the 3-floor car: latches hall/car calls into a pending set, picks the next target with a direction-preserving (SCAN) policy, and moves the car one floor at a time with a timed door sequence. It reports car position (F-style floor code) and door state (P-style), and adds movement/direction/pending status. An alarm input holds the door open when the car is stopped and freezes travel when the car is moving.

Parameters:
TRAVEL_CYCLES, 8, clock cycles to travel one floor (>=1)
DOOR_CYCLES, 4, clock cycles door stays open per service (>=1)
CW, 8, width of shared travel/door down-counter (must hold max(TRAVEL_CYCLES, DOOR_CYCLES)-1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
alarm  in  1  level; emergency/door-hold request
call  in  3  level; bit i = request for floor i, sampled every edge
floor  out  2  car position: 00 = floor 0, 01 = floor 1, 10 = floor 2; 11 is never driven
door  out  1  1 = door open
moving  out  1  1 = car travelling (state MOVE)
dir  out  1  1 = up, 0 = down (current/last direction)
pending  out  3  latched outstanding calls
busy  out  1  state != IDLE or pending != 0

Behaviour:
- Reset (reset=0, async): state=IDLE, floor=00, door=0, moving=0, dir=1, pending=000, cnt=0. Asserting reset mid-travel or mid-door aborts immediately; no resume.
- pending update each edge: pending <= (pending | call) & ~clr. clr = current-floor bit when entering DOOR, and current-floor bit while in DOOR (calls for the open floor are absorbed).
- Outputs are registered or decoded from state: door=1 in DOOR; moving=1 in MOVE; otherwise 0.
- above = pending bits with index > floor; below = pending bits with index < floor.
- State IDLE:
  - If alarm: go to DOOR with cnt=DOOR_CYCLES-1.
  - Else if pending[floor]: go to DOOR with cnt=DOOR_CYCLES-1 and clear that bit.
  - Else if dir=1 and above: go to MOVE up.
  - Else if dir=0 and below: go to MOVE down.
  - Else if above: set dir=1, go to MOVE.
  - Else if below: set dir=0, go to MOVE.
  - Else stay in IDLE.
  - Entry to MOVE loads cnt=TRAVEL_CYCLES-1.
- State MOVE: lasts exactly TRAVEL_CYCLES cycles.
  - If alarm: go to HALT, cnt frozen.
  - Else if cnt != 0: cnt-1.
  - Else (arrival edge): floor <= floor+1 if dir=1, floor-1 if dir=0. Then, if the pending bit of the new floor is set, go to DOOR (load DOOR_CYCLES-1, clear bit); otherwise go to IDLE, which decides next (1-cycle decision bubble).
- State HALT: moving=0, door=0, cnt and floor held. When alarm drops, return to MOVE with the remaining cnt. Calls keep latching, including the current-floor bit.
- State DOOR: lasts DOOR_CYCLES cycles.
  - If alarm, or call[floor]=1: reload cnt=DOOR_CYCLES-1 (door held/extended).
  - Else if cnt != 0: cnt-1.
  - Else: go to IDLE (door=0 on that edge).
- Floor never leaves the range 00..10: a move is only started when above/below is nonzero.
- Simultaneous events:
  - A call arriving on the same edge the car arrives at that floor does not open the door on that edge, because the arrival check uses registered pending. The bit latches, and IDLE opens the door next cycle.
  - If alarm and arrival coincide, alarm wins and the state goes to HALT with cnt=0. After release, arrival completes on the next edge.

Test Plan:
1. Reset: hold reset=0 with random call/alarm -> floor=00, door=0, moving=0, dir=1, pending=000, busy=0; deassert -> stays IDLE.
2. Single trip: at floor 0, pulse call=100 at edge t -> pending=100 at t, moving=1 from t+1, floor=01 at t+9, moving=1 again from t+10, floor=10 and door=1 at t+18, door=0 at t+22, pending=000.
3. SCAN order: car at floor 1 moving up with pending=101 -> serves floor 2 first (door), then dir=0 and serves floor 0; floor-1 call raised during door at floor 1 is absorbed (pending[1] stays 0) and the door extends 4 cycles.
4. Alarm during travel: assert alarm after 3 MOVE cycles for 10 cycles -> moving=0, floor unchanged, door=0; on release arrival occurs exactly 5 cycles later.
5. Alarm at rest: IDLE at floor 2, alarm=1 for 6 cycles -> door=1 throughout and for 4 cycles after release, then door=0; pending calls serviced afterwards.
6. Async reset mid-MOVE: reset=0 while cnt=3 -> immediately floor=00, moving=0, pending=000; no further motion after release without new calls.

Source files
------------

// File: rtl/elevator_scheduler.sv
// Three-floor elevator car controller.
// Calls are latched into a pending set. A direction-preserving (SCAN) policy
// picks the next floor. The car moves one floor per TRAVEL_CYCLES, and the door
// stays open for DOOR_CYCLES after each service. Alarm holds the door open
// while the car is stopped, and freezes travel while it is moving.
module elevator_scheduler #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int CW            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm,
  input  logic [2:0] call,
  output logic [1:0] floor,
  output logic       door,
  output logic       moving,
  output logic       dir,
  output logic [2:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HALT = 2'd2,
    DOOR = 2'd3
  } state_t;

  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  logic [2:0] above_mask;
  logic [2:0] below_mask;
  logic [2:0] above;
  logic [2:0] below;
  logic [1:0] arrive_floor;
  logic [2:0] floor_bit;
  logic [2:0] arrive_bit;
  logic [2:0] clr;

  // Floors strictly above and strictly below the car. The car never sits on the 11 code.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    above_mask = 3'b000;
    below_mask = 3'b000;
    case (floor)
      2'd0:    above_mask = 3'b110;
      2'd1:    begin above_mask = 3'b100; below_mask = 3'b001; end
      2'd2:    below_mask = 3'b011;
      default: ;
    endcase
  end

  assign above        = pending & above_mask;
  assign below        = pending & below_mask;
  assign arrive_floor = dir ? floor + 2'd1 : floor - 2'd1;
  assign floor_bit    = 3'b001 << floor;
  assign arrive_bit   = 3'b001 << arrive_floor;

  // A call for the floor whose door is opening or open is absorbed, not latched.
  always_comb begin
    clr = 3'b000;
    case (state)
      IDLE:    if (alarm || pending[floor]) clr = floor_bit;
      MOVE:    if (!alarm && cnt == '0 && pending[arrive_floor]) clr = arrive_bit;
      DOOR:    clr = floor_bit;
      default: ;
    endcase
  end

  // Controller FSM: position, direction, pending set and the shared travel/door counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      floor   <= 2'd0;
      dir     <= 1'b1;
      pending <= 3'b000;
      cnt     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment, so every branch below reads pre-edge values.
      pending <= (pending | call) & ~clr;
      case (state)
        IDLE: begin
          if (alarm || pending[floor]) begin
            state <= DOOR;
            cnt   <= DOOR_LOAD;
          end else if ((dir && |above) || (!dir && |below)) begin
            state <= MOVE;
            cnt   <= TRAVEL_LOAD;
          end else if (|above) begin
            dir   <= 1'b1;
            state <= MOVE;
            cnt   <= TRAVEL_LOAD;
          end else if (|below) begin
            dir   <= 1'b0;
            state <= MOVE;
            cnt   <= TRAVEL_LOAD;
          end
        end
        MOVE: begin
          if (alarm) begin
            state <= HALT;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            floor <= arrive_floor;
            if (pending[arrive_floor]) begin
              state <= DOOR;
              cnt   <= DOOR_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALT: begin
          if (!alarm) state <= MOVE;
        end
        DOOR: begin
          if (alarm || call[floor]) begin
            cnt <= DOOR_LOAD;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign door   = (state == DOOR);
  assign moving = (state == MOVE);
  assign busy   = (state != IDLE) || (pending != 3'b000);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Testbench for elevator_scheduler.
// Directed scenarios with hand-computed timing come first, then randomized
// calls, alarms and resets. A behavioural model, stepped every rising edge,
// predicts all outputs, and a compare process checks them each cycle.
module tb_elevator_scheduler;

  localparam int TRAVEL_CYCLES = 8;
  localparam int DOOR_CYCLES   = 4;

  logic       clk;
  logic       reset;
  logic       alarm;
  logic [2:0] call;
  logic [1:0] floor;
  logic       door;
  logic       moving;
  logic       dir;
  logic [2:0] pending;
  logic       busy;

  int tests  = 0;
  int failed = 0;

  elevator_scheduler #(
    .TRAVEL_CYCLES(TRAVEL_CYCLES),
    .DOOR_CYCLES  (DOOR_CYCLES),
    .CW           (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .alarm  (alarm),
    .call   (call),
    .floor  (floor),
    .door   (door),
    .moving (moving),
    .dir    (dir),
    .pending(pending),
    .busy   (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The car is modelled as an activity (at rest, travelling, frozen, door open)
  // plus the elapsed cycles spent in that activity.
  localparam int REST = 0, TRAVEL = 1, FROZEN = 2, OPEN = 3;
  int m_mode, m_fl, m_el;
  bit m_up;
  bit m_pend [3];

  task automatic model_reset();
    m_mode = REST; m_fl = 0; m_el = 0; m_up = 1'b1;
    for (int j = 0; j < 3; j++) m_pend[j] = 1'b0;
  endtask

  task automatic model_step(input bit a, input logic [2:0] c);
    int  nfl       = m_fl;
    int  nmode     = m_mode;
    int  clr_floor = -1;
    bit  any_above = 1'b0;
    bit  any_below = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (m_pend[j] && j > m_fl) any_above = 1'b1;
      if (m_pend[j] && j < m_fl) any_below = 1'b1;
    end
    case (m_mode)
      REST: begin
        if (a || m_pend[m_fl]) begin
          nmode = OPEN; m_el = 0; clr_floor = m_fl;
        end else begin
          // Keep heading the same way while there is work that way; otherwise turn around.
          if (!(m_up ? any_above : any_below)) begin
            if (any_above) m_up = 1'b1;
            else if (any_below) m_up = 1'b0;
          end
          if (any_above || any_below) begin
            nmode = TRAVEL; m_el = 0;
          end
        end
      end
      TRAVEL: begin
        if (a) nmode = FROZEN;
        else if (m_el < TRAVEL_CYCLES - 1) m_el++;
        else begin
          nfl = m_up ? m_fl + 1 : m_fl - 1;
          if (m_pend[nfl]) begin
            nmode = OPEN; m_el = 0; clr_floor = nfl;
          end else begin
            nmode = REST;
          end
        end
      end
      FROZEN: if (!a) nmode = TRAVEL;
      default: begin  // OPEN
        clr_floor = m_fl;
        if (a || c[m_fl]) m_el = 0;
        else if (m_el < DOOR_CYCLES - 1) m_el++;
        else nmode = REST;
      end
    endcase
    for (int j = 0; j < 3; j++) m_pend[j] = (m_pend[j] || c[j]) && (j != clr_floor);
    m_fl   = nfl;
    m_mode = nmode;
  endtask

  function automatic logic [8:0] model_out();
    logic [2:0] p;
    for (int j = 0; j < 3; j++) p[j] = m_pend[j];
    return {2'(m_fl), m_mode == OPEN, m_mode == TRAVEL, m_up, p,
            (m_mode != REST) || (p != 3'b000)};
  endfunction

  function automatic logic [8:0] dut_out();
    return {floor, door, moving, dir, pending, busy};
  endfunction

  // Step the model on each rising edge, then compare once the DUT outputs have settled.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset) model_reset();
      else model_step(alarm, call);
      #2;
      check("cycle {floor,door,moving,dir,pending,busy}", dut_out(), model_out());
    end
  end

  // ---------------- stimulus helpers ----------------
  // Wait for a condition for a bounded number of cycles; running out of cycles counts as a failure.
  // sel: 0 door open, 1 door closed, 2 moving, 3 not busy.
  task automatic wait_until(input int sel, input string name);
    int n = 0;
    bit ok;
    forever begin
      case (sel)
        0:       ok = door;
        1:       ok = !door;
        2:       ok = moving;
        default: ok = !busy;
      endcase
      if (ok || n >= 300) break;
      @(negedge clk);
      n++;
    end
    check(name, 16'(ok), 16'd1);
  endtask

  task automatic pulse_call(input logic [2:0] c);
    @(negedge clk); call = c;
    @(negedge clk); call = 3'b000;
  endtask

  initial begin
    reset = 1'b0; alarm = 1'b0; call = 3'b000;

    // 1. Reset holds, even with activity on the inputs.
    repeat (5) begin
      @(negedge clk);
      call  = 3'($urandom);
      alarm = 1'($urandom);
    end
    @(negedge clk);
    check("reset state", 16'(dut_out()), 16'(9'b00_0_0_1_000_0));
    call = 3'b000; alarm = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle after reset", 16'(dut_out()), 16'(9'b00_0_0_1_000_0));

    // 2. Single trip from floor 0 to floor 2.
    @(negedge clk); call = 3'b100;       // edge t latches the call
    @(negedge clk); call = 3'b000;
    check("trip pending at t", 16'({pending, moving}), 16'({3'b100, 1'b0}));
    @(negedge clk);
    check("trip moving at t+1", 16'(moving), 16'd1);
    repeat (8) @(negedge clk);
    check("trip floor1 at t+9", 16'({floor, moving}), 16'({2'd1, 1'b0}));
    @(negedge clk);
    check("trip moving at t+10", 16'(moving), 16'd1);
    repeat (8) @(negedge clk);
    check("trip door at t+18", 16'({floor, door}), 16'({2'd2, 1'b1}));
    repeat (3) @(negedge clk);
    check("trip door at t+21", 16'(door), 16'd1);
    @(negedge clk);
    check("trip closed at t+22", 16'({door, pending}), 16'({1'b0, 3'b000}));

    // 3. SCAN order: going up through floor 1 with pending 101 serves floor 2 first.
    pulse_call(3'b001);
    wait_until(0, "scan reach floor0");
    wait_until(3, "scan settle floor0");
    pulse_call(3'b100);
    wait_until(2, "scan start up");
    pulse_call(3'b001);
    check("scan pending 101", 16'(pending), 16'(3'b101));
    wait_until(0, "scan door first stop");
    check("scan first stop floor2 up", 16'({floor, dir}), 16'({2'd2, 1'b1}));
    wait_until(1, "scan door closes");
    wait_until(0, "scan door second stop");
    check("scan second stop floor0 down", 16'({floor, dir}), 16'({2'd0, 1'b0}));
    wait_until(3, "scan settle");
    pulse_call(3'b010);
    wait_until(0, "absorb door at floor1");
    @(negedge clk); call = 3'b010;
    @(negedge clk); call = 3'b000;
    check("absorb call at open floor", 16'({pending, door}), 16'({3'b000, 1'b1}));
    wait_until(3, "absorb settle");

    // 4. Alarm freezes travel; arrival follows 5 cycles after travel resumes.
    pulse_call(3'b001);
    wait_until(2, "alarm travel start");
    repeat (3) @(negedge clk);
    alarm = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("alarm halted", 16'({moving, door, floor}), 16'({1'b0, 1'b0, 2'd1}));
    end
    alarm = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("alarm resumed travel", 16'({moving, floor}), 16'({1'b1, 2'd1}));
    end
    @(negedge clk);
    check("alarm arrival", 16'({floor, door}), 16'({2'd0, 1'b1}));
    wait_until(3, "alarm settle");

    // 5. Alarm at rest holds the door, then the door runs its normal time.
    pulse_call(3'b100);
    wait_until(0, "rest reach floor2");
    wait_until(3, "rest settle floor2");
    @(negedge clk); alarm = 1'b1; call = 3'b001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); call = 3'b000;
      check("rest alarm door held", 16'(door), 16'd1);
    end
    alarm = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rest door after release", 16'(door), 16'd1);
    end
    @(negedge clk);
    check("rest door closes", 16'(door), 16'd0);
    wait_until(0, "rest serve pending");
    check("rest served floor0", 16'(floor), 16'd0);
    wait_until(3, "rest settle floor0");

    // 6. Asynchronous reset in the middle of travel.
    pulse_call(3'b100);
    wait_until(2, "reset travel start");
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("async reset immediate", 16'({floor, moving, door, pending}), 16'({2'd0, 1'b0, 1'b0, 3'b000}));
    @(negedge clk); reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no motion after reset", 16'({floor, moving, busy}), 16'({2'd0, 1'b0, 1'b0}));

    // Randomized traffic, alarms and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      call = 3'($urandom) & 3'($urandom) & 3'($urandom);
      if (alarm) alarm = ($urandom_range(0, 3) != 0);
      else       alarm = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    call = 3'b000; alarm = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
